// File: rtl/food_spawn_ctrl_if.sv
// Signal bundle between the food spawner, the game FSM, the RNGs and the
// snake-body occupancy lookup. The slave view belongs to food_spawn_ctrl.
interface food_spawn_ctrl_if;
    logic       SPAWN_REQ;
    logic [7:0] HORZ_RND;
    logic [7:0] VERT_RND;
    logic       HORZ_CE;
    logic       VERT_CE;
    logic       OCC_REQ;
    logic [7:0] OCC_X;
    logic [7:0] OCC_Y;
    logic       OCC_ACK;
    logic       OCC_HIT;
    logic [7:0] FOOD_X;
    logic [7:0] FOOD_Y;
    logic       FOOD_VALID;
    logic       SPAWN_DONE;
    logic       SPAWN_FAIL;
    logic       BUSY;

    modport master (
        output SPAWN_REQ, HORZ_RND, VERT_RND, OCC_ACK, OCC_HIT,
        input  HORZ_CE, VERT_CE, OCC_REQ, OCC_X, OCC_Y,
               FOOD_X, FOOD_Y, FOOD_VALID, SPAWN_DONE, SPAWN_FAIL, BUSY
    );

    modport slave (
        input  SPAWN_REQ, HORZ_RND, VERT_RND, OCC_ACK, OCC_HIT,
        output HORZ_CE, VERT_CE, OCC_REQ, OCC_X, OCC_Y,
               FOOD_X, FOOD_Y, FOOD_VALID, SPAWN_DONE, SPAWN_FAIL, BUSY
    );
endinterface

// File: rtl/food_spawn_ctrl.sv
// Picks a free, in-grid food cell by stepping the X/Y random generators and
// rejecting candidates that fall off the grid or land on the snake.
module food_spawn_ctrl #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_TRIES = 255
) (
    input logic            CLK,
    input logic            RESET,
    food_spawn_ctrl_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SAMPLE = 3'd1;
    localparam logic [2:0] STEP   = 3'd2;
    localparam logic [2:0] QUERY  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] FAIL   = 3'd5;

    localparam int           CW        = $clog2(MAX_TRIES + 1);
    localparam logic [CW:0]  TRY_LIMIT = (CW + 1)'(MAX_TRIES);
    localparam logic [8:0]   X_LIMIT   = 9'(GRID_W);
    localparam logic [8:0]   Y_LIMIT   = 9'(GRID_H);

    logic [2:0]    state;
    logic [CW-1:0] try_cnt;
    logic [CW:0]   try_next;
    logic [7:0]    cand_x;
    logic [7:0]    cand_y;
    logic [7:0]    food_x;
    logic [7:0]    food_y;
    logic          food_valid;
    logic          in_range;

    assign try_next = {1'b0, try_cnt} + (CW + 1)'(1);
    assign in_range = ({1'b0, bus.HORZ_RND} < X_LIMIT) &&
                      ({1'b0, bus.VERT_RND} < Y_LIMIT);

    // The food registers load on the QUERY->DONE edge so they are already
    // valid during the SPAWN_DONE cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            try_cnt    <= '0;
            cand_x     <= '0;
            cand_y     <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.SPAWN_REQ) begin
                        food_valid <= 1'b0;
                        try_cnt    <= '0;
                        state      <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    cand_x <= bus.HORZ_RND;
                    cand_y <= bus.VERT_RND;
                    state  <= in_range ? QUERY : STEP;
                end
                STEP: begin
                    try_cnt <= try_next[CW-1:0];
                    state   <= (try_next == TRY_LIMIT) ? FAIL : SAMPLE;
                end
                QUERY: begin
                    if (bus.OCC_ACK) begin
                        if (bus.OCC_HIT) begin
                            state <= STEP;
                        end else begin
                            food_x     <= cand_x;
                            food_y     <= cand_y;
                            food_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                FAIL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Generators only move in IDLE and STEP, never under a live query.
    assign bus.HORZ_CE    = (state == IDLE) || (state == STEP);
    assign bus.VERT_CE    = (state == IDLE) || (state == STEP);
    assign bus.OCC_REQ    = (state == QUERY);
    assign bus.OCC_X      = cand_x;
    assign bus.OCC_Y      = cand_y;
    assign bus.FOOD_X     = food_x;
    assign bus.FOOD_Y     = food_y;
    assign bus.FOOD_VALID = food_valid;
    assign bus.SPAWN_DONE = (state == DONE);
    assign bus.SPAWN_FAIL = (state == FAIL);
    assign bus.BUSY       = (state != IDLE);

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Self-checking bench for food_spawn_ctrl: table of spawn scenarios driven
// through a reactive RNG/occupancy model, results checked via a scoreboard.
module tb_food_spawn_ctrl;

    localparam int MAX_TRIES = 3;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    food_spawn_ctrl_if bus();

    food_spawn_ctrl #(
        .GRID_W(40),
        .GRID_H(30),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    typedef struct {
        logic [2:0][7:0] cx;
        logic [2:0][7:0] cy;
        logic [2:0]      hit;
        int              ackDelay;
        logic            dupReq;
        logic            expFail;
        logic [7:0]      expX;
        logic [7:0]      expY;
        int              expSteps;
        int              expLat;
        int              expOcc;
    } vec_t;

    typedef struct {
        logic       isFail;
        logic [7:0] x;
        logic [7:0] y;
        int         steps;
        int         cycle;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[8];

    int   checks = 0;
    int   failures = 0;
    int   cycleCnt = 0;
    int   monSteps = 0;
    logic monOn = 1'b0;
    logic prevReq = 1'b0;
    logic [7:0] prevX = '0;
    logic [7:0] prevY = '0;

    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    function automatic vec_t mkVec(input logic [7:0] x0, y0, x1, y1, x2, y2,
                                   input logic [2:0] hit, input int dly,
                                   input logic dup, fl, input logic [7:0] ex, ey,
                                   input int st, lat, occ);
        vec_t v;
        v.cx = {x2, x1, x0};
        v.cy = {y2, y1, y0};
        v.hit = hit;
        v.ackDelay = dly;
        v.dupReq = dup;
        v.expFail = fl;
        v.expX = ex;
        v.expY = ey;
        v.expSteps = st;
        v.expLat = lat;
        v.expOcc = occ;
        return v;
    endfunction

    // Monitor: CE rules, query stability, and scoreboard pops on completion.
    always @(negedge CLK) begin
        if (monOn) begin
            exp_t e;
            checkOutput("ce_pair", {31'd0, bus.HORZ_CE}, {31'd0, bus.VERT_CE});
            if (!bus.BUSY) checkOutput("idle_ce", {30'd0, bus.HORZ_CE, bus.VERT_CE}, 32'd3);
            if (bus.OCC_REQ) checkOutput("ce_in_query", {31'd0, bus.HORZ_CE}, 32'd0);
            if (bus.OCC_REQ && prevReq)
                checkOutput("occ_stable", {16'd0, bus.OCC_X, bus.OCC_Y}, {16'd0, prevX, prevY});
            if (!bus.BUSY) monSteps = 0;
            else if (bus.HORZ_CE) monSteps++;
            if (bus.SPAWN_DONE || bus.SPAWN_FAIL) begin
                checkOutput("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    checkOutput("result_kind", {30'd0, bus.SPAWN_FAIL, bus.SPAWN_DONE},
                                e.isFail ? 32'd2 : 32'd1);
                    checkOutput("food_valid", {31'd0, bus.FOOD_VALID}, {31'd0, !e.isFail});
                    if (!e.isFail)
                        checkOutput("food_xy", {16'd0, bus.FOOD_X, bus.FOOD_Y}, {16'd0, e.x, e.y});
                    checkOutput("step_count", monSteps, e.steps);
                    checkOutput("latency_cycle", cycleCnt, e.cycle);
                end
            end
            prevReq = bus.OCC_REQ;
            prevX = bus.OCC_X;
            prevY = bus.OCC_Y;
        end
    end

    // Drives one spawn request and plays RNG + occupancy responder until done.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        int   k = 0;
        int   waitCnt = 0;
        int   occCycles = 0;
        logic finished = 1'b0;
        @(posedge CLK); #1;
        bus.HORZ_RND = v.cx[0];
        bus.VERT_RND = v.cy[0];
        bus.OCC_ACK = 1'b1;
        bus.OCC_HIT = 1'b0;
        bus.SPAWN_REQ = 1'b1;
        e.isFail = v.expFail;
        e.x = v.expX;
        e.y = v.expY;
        e.steps = v.expSteps;
        e.cycle = cycleCnt + v.expLat;
        sbq.push_back(e);
        @(posedge CLK); #1;
        bus.SPAWN_REQ = 1'b0;
        checkOutput($sformatf("v%0d_busy_start", idx), {31'd0, bus.BUSY}, 32'd1);
        checkOutput($sformatf("v%0d_valid_cleared", idx), {31'd0, bus.FOOD_VALID}, 32'd0);
        for (int c = 0; c < 60; c++) begin
            bus.SPAWN_REQ = 1'b0;
            if (bus.SPAWN_DONE || bus.SPAWN_FAIL) begin
                finished = 1'b1;
                if (v.dupReq) bus.SPAWN_REQ = 1'b1;
                break;
            end
            if (v.dupReq && c == 1) bus.SPAWN_REQ = 1'b1;
            if (bus.HORZ_CE && bus.BUSY) begin
                k = (k < 2) ? k + 1 : 2;
                bus.HORZ_RND = v.cx[k];
                bus.VERT_RND = v.cy[k];
            end
            if (bus.OCC_REQ) begin
                occCycles++;
                checkOutput($sformatf("v%0d_occ_xy", idx), {16'd0, bus.OCC_X, bus.OCC_Y},
                            {16'd0, v.cx[k], v.cy[k]});
                bus.OCC_ACK = (waitCnt >= v.ackDelay);
                bus.OCC_HIT = v.hit[k];
                waitCnt++;
            end else begin
                waitCnt = 0;
                bus.OCC_ACK = 1'b1;
                bus.OCC_HIT = 1'b0;
            end
            @(posedge CLK); #1;
        end
        checkOutput($sformatf("v%0d_completed", idx), {31'd0, finished}, 32'd1);
        checkOutput($sformatf("v%0d_occ_cycles", idx), occCycles, v.expOcc);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            bus.SPAWN_REQ = 1'b0;
            checkOutput($sformatf("v%0d_idle_after", idx), {31'd0, bus.BUSY}, 32'd0);
        end
        checkOutput($sformatf("v%0d_valid_held", idx), {31'd0, bus.FOOD_VALID}, {31'd0, !v.expFail});
        if (!v.expFail)
            checkOutput($sformatf("v%0d_food_held", idx), {16'd0, bus.FOOD_X, bus.FOOD_Y},
                        {16'd0, v.expX, v.expY});
    endtask

    initial begin
        vecs[0] = mkVec(12, 7, 12, 7, 12, 7, 3'b000, 0, 0, 0, 12, 7, 0, 3, 1);
        vecs[1] = mkVec(45, 7, 3, 29, 3, 29, 3'b000, 0, 0, 0, 3, 29, 1, 5, 1);
        vecs[2] = mkVec(5, 30, 39, 29, 39, 29, 3'b000, 0, 0, 0, 39, 29, 1, 5, 1);
        vecs[3] = mkVec(40, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1, 5, 1);
        vecs[4] = mkVec(5, 5, 6, 5, 6, 5, 3'b001, 4, 0, 0, 6, 5, 1, 14, 10);
        vecs[5] = mkVec(200, 200, 200, 200, 200, 200, 3'b000, 0, 1, 1, 0, 0, 3, 7, 0);
        vecs[6] = mkVec(7, 7, 7, 7, 7, 7, 3'b111, 0, 0, 1, 0, 0, 3, 10, 3);
        vecs[7] = mkVec(255, 29, 39, 30, 39, 29, 3'b000, 0, 0, 0, 39, 29, 2, 7, 1);

        RESET = 1'b1;
        bus.SPAWN_REQ = 1'b0;
        bus.HORZ_RND = '0;
        bus.VERT_RND = '0;
        bus.OCC_ACK = 1'b0;
        bus.OCC_HIT = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        checkOutput("rst_food", {15'd0, bus.FOOD_VALID, bus.FOOD_X, bus.FOOD_Y}, 32'd0);
        checkOutput("rst_pulses", {29'd0, bus.SPAWN_DONE, bus.SPAWN_FAIL, bus.OCC_REQ}, 32'd0);
        checkOutput("rst_ce", {30'd0, bus.HORZ_CE, bus.VERT_CE}, 32'd3);
        RESET = 1'b0;
        monOn = 1'b1;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

        // Reset while a query is outstanding must abort without a pulse.
        @(posedge CLK); #1;
        bus.HORZ_RND = 8'd10;
        bus.VERT_RND = 8'd10;
        bus.OCC_ACK = 1'b0;
        bus.SPAWN_REQ = 1'b1;
        @(posedge CLK); #1;
        bus.SPAWN_REQ = 1'b0;
        for (int c = 0; c < 10 && !bus.OCC_REQ; c++) begin
            @(posedge CLK); #1;
        end
        checkOutput("rstq_in_query", {31'd0, bus.OCC_REQ}, 32'd1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        checkOutput("rstq_occ_req", {31'd0, bus.OCC_REQ}, 32'd0);
        checkOutput("rstq_busy", {31'd0, bus.BUSY}, 32'd0);
        checkOutput("rstq_food", {15'd0, bus.FOOD_VALID, bus.FOOD_X, bus.FOOD_Y}, 32'd0);
        checkOutput("rstq_pulses", {30'd0, bus.SPAWN_DONE, bus.SPAWN_FAIL}, 32'd0);
        bus.OCC_ACK = 1'b1;

        applyStimulus(vecs[0], 8);

        repeat (2) @(posedge CLK);
        checkOutput("sb_drained", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
